// File: rtl/conv_sequencer.sv
// Layer sequencer for the convolution corelet: walks each kernel position through
// weight load, kernel load, activation load, execute, drain and psum store, then accumulates.
module conv_sequencer #(
    parameter int COL  = 8,
    parameter int NPIX = 16,
    parameter int NKIJ = 9,
    parameter int GAP  = 8,
    parameter int AW   = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          l0_full,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] psum_addr,
    output logic          psum_we,
    output logic          busy,
    output logic          done
);

    localparam int B_LOAD  = 0;
    localparam int B_EXEC  = 1;
    localparam int B_L0WR  = 2;
    localparam int B_L0RD  = 3;
    localparam int B_OFRD  = 6;
    localparam int B_ACC   = 33;

    typedef enum logic [3:0] {
        IDLE, WLD, WKR, WGAP, XLD, XEX, DRN, ORD, ACC, FIN
    } state_t;

    state_t        state, state_n;
    logic [31:0]   cnt, cnt_n, kij, kij_n;
    logic [33:0]   inst_n;
    logic [AW-1:0] w_addr_n, x_addr_n, psum_addr_n;
    logic          psum_we_n, done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            kij       <= '0;
            inst      <= '0;
            w_addr    <= '0;
            x_addr    <= '0;
            psum_addr <= '0;
            psum_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            kij       <= kij_n;
            inst      <= inst_n;
            w_addr    <= w_addr_n;
            x_addr    <= x_addr_n;
            psum_addr <= psum_addr_n;
            psum_we   <= psum_we_n;
            busy      <= (state != IDLE);
            done      <= done_n;
        end
    end

    // Outputs are computed from the current state and registered, so they trail the state by one cycle.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        kij_n       = kij;
        inst_n      = '0;
        w_addr_n    = w_addr;
        x_addr_n    = x_addr;
        psum_addr_n = psum_addr;
        psum_we_n   = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = WLD;
                    cnt_n   = '0;
                    kij_n   = '0;
                end
            end
            WLD: begin
                // While L0 is full the address stays on the pending beat and no write is issued.
                w_addr_n = AW'(kij * COL + cnt);
                if (!l0_full) begin
                    inst_n[B_L0WR] = 1'b1;
                    if (cnt == COL - 1) begin
                        cnt_n   = '0;
                        state_n = WKR;
                    end else begin
                        cnt_n = cnt + 1;
                    end
                end
            end
            WKR: begin
                inst_n[B_LOAD] = 1'b1;
                inst_n[B_L0RD] = 1'b1;
                if (cnt == COL - 1) begin
                    cnt_n   = '0;
                    state_n = WGAP;
                end else begin
                    cnt_n = cnt + 1;
                end
            end
            WGAP: begin
                if (cnt == GAP - 1) begin
                    cnt_n   = '0;
                    state_n = XLD;
                end else begin
                    cnt_n = cnt + 1;
                end
            end
            XLD: begin
                x_addr_n = AW'(kij * NPIX + cnt);
                if (!l0_full) begin
                    inst_n[B_L0WR] = 1'b1;
                    if (cnt == NPIX - 1) begin
                        cnt_n   = '0;
                        state_n = XEX;
                    end else begin
                        cnt_n = cnt + 1;
                    end
                end
            end
            XEX: begin
                inst_n[B_EXEC] = 1'b1;
                inst_n[B_L0RD] = 1'b1;
                if (cnt == NPIX - 1) begin
                    cnt_n   = '0;
                    state_n = DRN;
                end else begin
                    cnt_n = cnt + 1;
                end
            end
            DRN: begin
                if (ofifo_valid) state_n = ORD;
            end
            ORD: begin
                psum_addr_n = AW'(kij * NPIX + cnt);
                if (ofifo_valid) begin
                    inst_n[B_OFRD] = 1'b1;
                    psum_we_n      = 1'b1;
                    if (cnt == NPIX - 1) begin
                        cnt_n = '0;
                        if (kij == NKIJ - 1) begin
                            kij_n   = '0;
                            state_n = ACC;
                        end else begin
                            kij_n   = kij + 1;
                            state_n = WLD;
                        end
                    end else begin
                        cnt_n = cnt + 1;
                    end
                end
            end
            ACC: begin
                // kij runs fastest here so all kernel positions of one pixel are read back to back.
                inst_n[B_ACC] = 1'b1;
                psum_addr_n   = AW'(kij * NPIX + cnt);
                if (kij == NKIJ - 1) begin
                    kij_n = '0;
                    if (cnt == NPIX - 1) begin
                        cnt_n   = '0;
                        state_n = FIN;
                    end else begin
                        cnt_n = cnt + 1;
                    end
                end else begin
                    kij_n = kij + 1;
                end
            end
            FIN: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer with default parameters.
module tb_conv_sequencer;

    localparam int COL  = 8;
    localparam int NPIX = 16;
    localparam int NKIJ = 9;
    localparam int GAP  = 8;
    localparam int AW   = 11;
    localparam int PER_KIJ = 73;
    localparam int TOTAL   = 802;
    localparam logic [33:0] USED_MASK = 34'h2_0000_007F;

    logic          clk = 1'b0;
    logic          reset, start, l0_full, ofifo_valid;
    logic [33:0]   inst;
    logic [AW-1:0] w_addr, x_addr, psum_addr;
    logic          psum_we, busy, done;

    int tests = 0;
    int fails = 0;
    int wr_count, acc_beat, done_count, n, writes;
    bit got_done;

    int exp_wr[11]   = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    int exp_addr[11] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};

    conv_sequencer #(.COL(COL), .NPIX(NPIX), .NKIJ(NKIJ), .GAP(GAP), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .l0_full(l0_full),
        .ofifo_valid(ofifo_valid), .inst(inst), .w_addr(w_addr), .x_addr(x_addr),
        .psum_addr(psum_addr), .psum_we(psum_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] exp_inst0(input int c);
        if (c <= 8) return 34'h4;
        if (c <= 16) return 34'h9;
        if (c <= 24) return 34'h0;
        if (c <= 40) return 34'h4;
        if (c <= 56) return 34'hA;
        if (c == 57) return 34'h0;
        return 34'h40;
    endfunction

    task automatic clear();
        wr_count   = 0;
        acc_beat   = 0;
        done_count = 0;
    endtask

    // One clock, sampled 1 time unit after the edge, with the always-on invariants and stream checks.
    task automatic tick();
        @(posedge clk);
        #1;
        check("no_load_exec", 64'(inst[0] & inst[1]), 64'(0));
        check("no_wr_rd", 64'(inst[2] & inst[3]), 64'(0));
        check("unused_bits", 64'(inst & ~USED_MASK), 64'(0));
        check("we_eq_ofifo_rd", 64'(psum_we), 64'(inst[6]));
        if (inst[33]) begin
            check("acc_addr", 64'(psum_addr), 64'((acc_beat % NKIJ) * NPIX + acc_beat / NKIJ));
            acc_beat++;
        end
        if (psum_we) begin
            check("psum_wr_addr", 64'(psum_addr), 64'(wr_count));
            wr_count++;
        end
        if (done) done_count++;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0;
        clear();
        tick();
        tick();
        check("rst_inst", 64'(inst), 64'(0));
        check("rst_w_addr", 64'(w_addr), 64'(0));
        check("rst_x_addr", 64'(x_addr), 64'(0));
        check("rst_psum_addr", 64'(psum_addr), 64'(0));
        check("rst_psum_we", 64'(psum_we), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'(0));

        // L0 full for three cycles while beat 4 of the weight load is pending.
        clear();
        writes = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            l0_full = (k >= 5 && k <= 7);
            tick();
            check("stall_l0_wr", 64'(inst[2]), 64'(exp_wr[k-1]));
            check("stall_w_addr", 64'(w_addr), 64'(exp_addr[k-1]));
            if (inst[2]) writes++;
        end
        l0_full = 1'b0;
        tick();
        check("stall_then_wkr", 64'(inst), 64'(34'h9));
        check("stall_write_count", 64'(writes), 64'(8));
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Full layer with l0_full low and ofifo_valid high; stray starts while busy must be ignored.
        clear();
        ofifo_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        got_done = 1'b0;
        while (!got_done && n < 3000) begin
            start = (n == 100 || n == 700);
            tick();
            start = 1'b0;
            n++;
            check("run_busy", 64'(busy), 64'(1));
            if (n <= PER_KIJ) check("kij0_inst", 64'(inst), 64'(exp_inst0(n)));
            if (n <= 8) check("kij0_w_addr", 64'(w_addr), 64'(n - 1));
            if (n >= 25 && n <= 40) check("kij0_x_addr", 64'(x_addr), 64'(n - 25));
            if (n == PER_KIJ + 1) check("kij1_w_addr", 64'(w_addr), 64'(COL));
            if (done) got_done = 1'b1;
        end
        check("total_cycles", 64'(n), 64'(TOTAL));
        check("psum_writes", 64'(wr_count), 64'(NPIX * NKIJ));
        check("last_psum_addr", 64'(psum_addr), 64'(143));
        check("acc_beats", 64'(acc_beat), 64'(NPIX * NKIJ));
        tick();
        check("post_done_busy", 64'(busy), 64'(0));
        check("post_done_pulse", 64'(done), 64'(0));
        repeat (5) tick();
        check("done_once", 64'(done_count), 64'(1));

        // ofifo_valid toggling: stores only happen on valid cycles and stay contiguous.
        clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        got_done = 1'b0;
        while (!got_done && n < 4000) begin
            ofifo_valid = (n % 2 == 0);
            tick();
            n++;
            if (psum_we) check("we_only_valid", 64'(ofifo_valid), 64'(1));
            if (done) got_done = 1'b1;
        end
        ofifo_valid = 1'b1;
        check("toggle_finished", 64'(got_done), 64'(1));
        check("toggle_writes", 64'(wr_count), 64'(NPIX * NKIJ));
        check("toggle_done_once", 64'(done_count), 64'(1));
        tick();

        // Reset during execute of kernel position 3 abandons the layer.
        clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3 * PER_KIJ + 46; k++) tick();
        check("xex3_inst", 64'(inst), 64'(34'hA));
        check("xex3_x_addr", 64'(x_addr), 64'(63));
        check("xex3_writes", 64'(wr_count), 64'(48));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_inst", 64'(inst), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_w_addr", 64'(w_addr), 64'(0));
        check("abort_x_addr", 64'(x_addr), 64'(0));
        check("abort_psum_addr", 64'(psum_addr), 64'(0));
        check("abort_psum_we", 64'(psum_we), 64'(0));
        repeat (10) tick();
        check("abort_no_done", 64'(done_count), 64'(0));
        check("abort_idle_busy", 64'(busy), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart_inst", 64'(inst), 64'(34'h4));
        check("restart_w_addr0", 64'(w_addr), 64'(0));
        tick();
        check("restart_w_addr1", 64'(w_addr), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter COL, default 8, MAC array columns = weight rows loaded per kernel position.
REQ-002 Parameter NPIX, default 16, output pixels processed per kernel position.
REQ-003 Parameter NKIJ, default 9, kernel positions per layer.
REQ-004 Parameter GAP, default 8, idle cycles between weight load and activation load.
REQ-005 Parameter AW, default 11, SRAM address width.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 start  input  1  one-cycle pulse; begins a layer when in IDLE.
REQ-009 l0_full  input  1  L0 full flag.
REQ-010 ofifo_valid  input  1  output FIFO holds a complete readable row.
REQ-011 inst  output  34  corelet control word: bit0 load, bit1 execute, bit2 l0_wr, bit3 l0_rd, bit4 ififo_rd, bit5 ififo_wr, bit6 ofifo_rd, bit33 acc; all other bits 0.
REQ-012 w_addr  output  AW  weight SRAM read address.
REQ-013 x_addr  output  AW  activation SRAM read address.
REQ-014 psum_addr  output  AW  psum SRAM write address (ORD) or read address (ACC).
REQ-015 psum_we  output  1  psum SRAM write enable.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse on layer completion.

Function
REQ-018 All outputs shall be registered; inst/address/enables shall be valid the cycle after the state/counter update that produces them.
REQ-019 States: IDLE, WLD, WKR, WGAP, XLD, XEX, DRN, ORD, ACC, FIN; counters cnt (beat), kij (0..NKIJ-1).
REQ-020 IDLE: inst=0; start -> WLD, cnt=0, kij=0; start ignored in all other states.
REQ-021 WLD: l0_wr=1, w_addr=kij*COL+cnt for COL beats; beat advances only when l0_full=0 (l0_wr=0 and address held while full); after beat COL-1 -> WKR.
REQ-022 WKR: l0_rd=1 and load=1 for COL cycles -> WGAP.
REQ-023 WGAP: inst=0 for GAP cycles -> XLD.
REQ-024 XLD: l0_wr=1, x_addr=kij*NPIX+cnt for NPIX beats, same l0_full stall rule as WLD -> XEX.
REQ-025 XEX: l0_rd=1 and execute=1 for NPIX cycles -> DRN.
REQ-026 DRN: inst=0 until ofifo_valid=1 -> ORD.
REQ-027 ORD: ofifo_rd=1 and psum_we=1 with psum_addr=kij*NPIX+cnt only on cycles where ofifo_valid=1; beat advances only on those cycles; after NPIX beats: kij<NKIJ-1 -> kij+1, WLD; else -> ACC.
REQ-028 ACC: acc (bit33)=1, psum_addr=p*NPIX... ordered kij-major per pixel: beat b reads address (b mod NKIJ)*NPIX+(b div NKIJ), for NPIX*NKIJ cycles -> FIN.
REQ-029 FIN: done=1 for one cycle, inst=0 -> IDLE.
REQ-030 At most one of load/execute shall be high in any cycle; l0_wr and l0_rd shall never be high together.
REQ-031 Counter and address arithmetic shall be unsigned, truncated to AW bits.
REQ-032 l0_full rising mid-WLD/XLD shall freeze cnt and addresses; deasserting resumes at the frozen beat with no skipped or duplicated address.

Reset
REQ-033 reset=1 in any state shall, at the next edge, force IDLE, cnt=0, kij=0, inst=0, all addresses 0, psum_we=0, busy=0, done=0, overriding start.
REQ-034 Reset mid-layer shall abandon the layer; no done pulse shall be emitted.

Verification
REQ-035 Default params, start, l0_full=0, ofifo_valid=1 from DRN on -> WLD w_addr 0..7, WKR 8 cycles bits0+3, 8 idle, x_addr 0..15, then kij=8 ends with psum_addr 128..143, ACC 144 cycles, done exactly once, total cycles match formula.
REQ-036 l0_full=1 for 3 cycles at WLD beat 4 -> w_addr holds 4 with l0_wr=0 for 3 cycles, then 5,6,7; exactly 8 writes.
REQ-037 ofifo_valid toggling 1,0 in ORD -> ofifo_rd/psum_we only on valid cycles; 16 writes, addresses contiguous.
REQ-038 Reset asserted during XEX of kij=3 -> next cycle IDLE, inst=0, busy=0; new start restarts at w_addr 0.
REQ-039 start pulses while busy -> no effect on state, counters, or done count.
REQ-040 Every cycle check: never load&execute, never l0_wr&l0_rd, unused inst bits 0.
